// File: rtl/serial_compare_msb_sequencer_pkg.sv
// Shared types and helpers for the MSB-first serial comparator sequencer.
package serial_cmp_pkg;

  // Sequencer control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SHIFT  = 2'd2,
    RESULT = 2'd3
  } seq_state_t;

  // Captured comparison result; err flags a non one-hot flag set
  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
    logic err;
  } cmp_result_t;

  localparam cmp_result_t RESULT_NONE = 4'b0000;

  // Returns 1 when exactly one of the three flags is set
  function automatic logic onehot3(input logic [2:0] flags);
    logic oh_s;
    case (flags)
      3'b001, 3'b010, 3'b100: oh_s = 1'b1;
      default:                oh_s = 1'b0;
    endcase
    return oh_s;
  endfunction

endpackage

// File: rtl/serial_compare_msb_sequencer_shifter.sv
// Parallel-load shift register presenting its MSB; shifts left one bit per
// enabled cycle with zero fill. One instance per operand.
module serial_word_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             dout_msb
);

  logic [WIDTH-1:0] sh_r;

  // Load has priority over shift; otherwise the word is held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_r <= '0;
    end else if (load) begin
      sh_r <= din;
    end else if (shift_en) begin
      sh_r <= {sh_r[WIDTH-2:0], 1'b0};
    end else begin
      sh_r <= sh_r;
    end
  end

  assign dout_msb = sh_r[WIDTH-1];

endmodule

// File: rtl/serial_compare_msb_sequencer.sv
// Upstream driver and result collector for an MSB-first serial comparator.
// Accepts an operand pair, clears the comparator for one cycle, shifts both
// words out MSB first and captures lt/eq/gt on the LSB cycle into a held
// result with its own valid/ready handshake.
module serial_compare_msb_sequencer
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             cmp_rst,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_lt,
  output logic             res_eq,
  output logic             res_gt,
  output logic             res_err
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_FIRST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  seq_state_t       state_r;
  seq_state_t       state_s;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [CNT_W-1:0] bit_cnt_s;
  cmp_result_t      res_r;
  cmp_result_t      res_s;

  logic accept_s;
  logic shift_s;
  logic last_s;
  logic clear_s;
  logic msb_a_s;
  logic msb_b_s;

  // Handshake and phase decode; in_ready also sees res_ready so a held
  // result can be retired in the same cycle a new pair is accepted
  always_comb begin
    clear_s  = (state_r == CLEAR);
    shift_s  = (state_r == SHIFT);
    last_s   = shift_s && (bit_cnt_r == '0);
    in_ready = (state_r == IDLE) || ((state_r == RESULT) && res_ready);
    accept_s = in_valid && in_ready;
  end

  // One shifter per operand; a load only happens on an accepted pair
  serial_word_shifter #(
    .WIDTH (WIDTH)
  ) u_shift_a (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_s),
    .shift_en (shift_s),
    .din      (in_a),
    .dout_msb (msb_a_s)
  );

  serial_word_shifter #(
    .WIDTH (WIDTH)
  ) u_shift_b (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_s),
    .shift_en (shift_s),
    .din      (in_b),
    .dout_msb (msb_b_s)
  );

  // Next-state logic for the IDLE -> CLEAR -> SHIFT -> RESULT sequence
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = CLEAR;
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        state_s = SHIFT;
      end
      SHIFT: begin
        if (last_s) begin
          state_s = RESULT;
        end else begin
          state_s = SHIFT;
        end
      end
      RESULT: begin
        if (accept_s) begin
          state_s = CLEAR;
        end else if (res_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESULT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Bit counter: preset in CLEAR, counts down to zero across SHIFT
  always_comb begin
    bit_cnt_s = bit_cnt_r;
    if (clear_s) begin
      bit_cnt_s = CNT_FIRST_BIT;
    end else if (shift_s && !last_s) begin
      bit_cnt_s = bit_cnt_r - CNT_ONE;
    end else begin
      bit_cnt_s = bit_cnt_r;
    end
  end

  // Result capture on the LSB cycle; comparator flags are already final
  // there because they are combinational on the current bit
  always_comb begin
    res_s = res_r;
    if (last_s) begin
      res_s.lt  = cmp_lt;
      res_s.eq  = cmp_eq;
      res_s.gt  = cmp_gt;
      res_s.err = ~onehot3({cmp_lt, cmp_eq, cmp_gt});
    end else begin
      res_s = res_r;
    end
  end

  // State, counter and result registers; reset discards any in-flight word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      bit_cnt_r <= '0;
      res_r     <= RESULT_NONE;
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      res_r     <= res_s;
    end
  end

  // Comparator is held cleared through reset and for the CLEAR cycle
  assign cmp_rst   = ~rst | clear_s;

  // Serial lanes idle at zero outside SHIFT so the comparator state holds
  assign ser_a     = shift_s & msb_a_s;
  assign ser_b     = shift_s & msb_b_s;
  assign ser_valid = shift_s;
  assign ser_last  = last_s;

  assign res_valid = (state_r == RESULT);
  assign res_lt    = res_r.lt;
  assign res_eq    = res_r.eq;
  assign res_gt    = res_r.gt;
  assign res_err   = res_r.err;

endmodule

// File: tb/tb_serial_compare_msb_sequencer.sv
// Directed bench for serial_compare_msb_sequencer (WIDTH=8) with a small
// MSB-first comparator model downstream and a flag-force bypass.
module tb_serial_compare_msb_sequencer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = 8'h00;
  logic [WIDTH-1:0] in_b = 8'h00;
  logic             cmp_rst;
  logic             ser_a, ser_b, ser_valid, ser_last;
  logic             cmp_lt, cmp_eq, cmp_gt;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic             res_lt, res_eq, res_gt, res_err;

  logic             byp = 1'b0;
  logic [2:0]       frc = 3'b000;   // {lt,eq,gt} forced onto comparator inputs

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_compare_msb_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .cmp_rst   (cmp_rst),
    .ser_a     (ser_a),
    .ser_b     (ser_b),
    .ser_valid (ser_valid),
    .ser_last  (ser_last),
    .cmp_lt    (cmp_lt),
    .cmp_eq    (cmp_eq),
    .cmp_gt    (cmp_gt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_lt    (res_lt),
    .res_eq    (res_eq),
    .res_gt    (res_gt),
    .res_err   (res_err)
  );

  // Comparator model: 0 = equal so far, 1 = a<b decided, 2 = a>b decided
  logic [1:0] mst = 2'd0;
  always @(posedge clk) begin
    if (cmp_rst) mst <= 2'd0;
    else if (ser_valid && mst == 2'd0 && ser_a != ser_b) mst <= ser_a ? 2'd2 : 2'd1;
  end
  wire diff_now = ser_valid && (ser_a != ser_b);
  wire m_lt = (mst == 2'd1) || (mst == 2'd0 && diff_now && !ser_a);
  wire m_gt = (mst == 2'd2) || (mst == 2'd0 && diff_now && ser_a);
  wire m_eq = (mst == 2'd0) && !diff_now;
  assign cmp_lt = byp ? frc[2] : m_lt;
  assign cmp_eq = byp ? frc[1] : m_eq;
  assign cmp_gt = byp ? frc[0] : m_gt;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       byp;
    logic [2:0] flags;
    logic [3:0] exp;   // {lt, eq, gt, err}
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present a pair and wait (bounded) until the coming edge accepts it
  task automatic start_word(input logic [7:0] a, input logic [7:0] b);
    int n;
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1; res_ready = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_wait", in_ready, 1);
  endtask

  // Follows one word from the cycle after accept through its result cycle
  task automatic follow_word(input logic [7:0] a, input logic [7:0] b, input logic [3:0] exp,
                             input logic nv, input logic [7:0] na, input logic [7:0] nb);
    @(negedge clk);
    in_valid = nv; in_a = na; in_b = nb;
    #1;
    chk("clear_cmp_rst", cmp_rst, 1);
    chk("clear_ser_valid", ser_valid, 0);
    chk("clear_res_valid", res_valid, 0);
    chk("clear_in_ready", in_ready, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("shift_ser_valid", ser_valid, 1);
      chk("shift_ser_a", ser_a, a[7-i]);
      chk("shift_ser_b", ser_b, b[7-i]);
      chk("shift_ser_last", ser_last, (i == 7) ? 1 : 0);
      chk("shift_cmp_rst", cmp_rst, 0);
      chk("shift_res_valid", res_valid, 0);
      chk("shift_in_ready", in_ready, 0);
    end
    @(negedge clk);
    #1;
    chk("result_valid", res_valid, 1);
    chk("result_flags", {res_lt, res_eq, res_gt, res_err}, exp);
    chk("result_ser_valid", ser_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'hA5, 8'h5A, 1'b0, 3'b000, 4'b0010};
    vecs[1]  = '{8'h3C, 8'h3C, 1'b0, 3'b000, 4'b0100};
    vecs[2]  = '{8'h01, 8'h80, 1'b0, 3'b000, 4'b1000};
    vecs[3]  = '{8'hFF, 8'h00, 1'b0, 3'b000, 4'b0010};
    vecs[4]  = '{8'h00, 8'hFF, 1'b0, 3'b000, 4'b1000};
    vecs[5]  = '{8'h00, 8'h00, 1'b0, 3'b000, 4'b0100};
    vecs[6]  = '{8'h7F, 8'h80, 1'b0, 3'b000, 4'b1000};
    vecs[7]  = '{8'hFE, 8'hFF, 1'b0, 3'b000, 4'b1000};
    vecs[8]  = '{8'hA5, 8'h5A, 1'b1, 3'b101, 4'b1011};
    vecs[9]  = '{8'h12, 8'h34, 1'b1, 3'b000, 4'b0001};
    vecs[10] = '{8'h12, 8'h34, 1'b1, 3'b111, 4'b1111};
    vecs[11] = '{8'h01, 8'h80, 1'b1, 3'b010, 4'b0100};

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_cmp_rst", cmp_rst, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_ser_last", ser_last, 0);
    chk("rst_ser_ab", {ser_a, ser_b}, 0);
    chk("rst_res_flags", {res_lt, res_eq, res_gt, res_err}, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_cmp_rst", cmp_rst, 0);

    // Table-driven single words, including forced-flag error cases
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      byp = vecs[i].byp; frc = vecs[i].flags;
      start_word(vecs[i].a, vecs[i].b);
      follow_word(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, 8'h00, 8'h00);
    end
    byp = 1'b0; frc = 3'b000;

    // Backpressure: result held 5 cycles, new pair ignored until res_ready
    start_word(8'h96, 8'h69);
    res_ready = 1'b0;
    follow_word(8'h96, 8'h69, 4'b0010, 1'b0, 8'h00, 8'h00);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22;
      #1;
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_flags", {res_lt, res_eq, res_gt, res_err}, 4'b0010);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_ser_valid", ser_valid, 0);
    end
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    follow_word(8'h11, 8'h22, 4'b1000, 1'b0, 8'h00, 8'h00);

    // Back-to-back stream of four pairs, one result every 10 cycles
    start_word(8'h10, 8'h20);
    follow_word(8'h10, 8'h20, 4'b1000, 1'b1, 8'h20, 8'h10);
    chk("stream_in_ready0", in_ready, 1);
    follow_word(8'h20, 8'h10, 4'b0010, 1'b1, 8'h55, 8'h55);
    chk("stream_in_ready1", in_ready, 1);
    follow_word(8'h55, 8'h55, 4'b0100, 1'b1, 8'hC0, 8'hC1);
    chk("stream_in_ready2", in_ready, 1);
    follow_word(8'hC0, 8'hC1, 4'b1000, 1'b0, 8'h00, 8'h00);

    // Reset during SHIFT bit 4 discards the word
    start_word(8'hC3, 8'h3C);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) @(negedge clk);
    chk("mid_ser_valid_before", ser_valid, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_cmp_rst", cmp_rst, 1);
    chk("mid_rst_ser_valid", ser_valid, 0);
    chk("mid_rst_ser_last", ser_last, 0);
    chk("mid_rst_ser_ab", {ser_a, ser_b}, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_flags", {res_lt, res_eq, res_gt, res_err}, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("post_rst_res_valid", res_valid, 0);
      chk("post_rst_ser_valid", ser_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
